ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Initiator/master for Pipelined_RAM: accepts single read/write requests on a valid/ready
//  port, drives the RAM strobes, addr and din, waits out the RAM read pipeline, then returns
//  read data with a parity-error flag.
//  Sits between a requesting engine (DMA/CPU side) and one Pipelined_RAM instance.
// PARAMETERS
//  MEM_WIDTH   16  data width; must match the RAM
//  ADDR_SIZE   10  address width; must match the RAM
//  RD_LATENCY  2   cycles from the ram_rd_en cycle to valid ram_dout; 1..7.
//                  Use 2 for DOUT_PIPELINE="TRUE", 1 for "FALSE".
// PORTS
//  clk            in   1          clock; all state changes on posedge
//  rst            in   1          asynchronous reset, active-high
//  req_valid      in   1          request present
//  req_ready      out  1          controller idle; request accepted when valid&&ready at posedge
//  req_wr         in   1          1=write, 0=read
//  req_addr       in   ADDR_SIZE  request address
//  req_wdata      in   MEM_WIDTH  write data
//  rsp_valid      out  1          one-cycle pulse, read data valid; no backpressure
//  rsp_rdata      out  MEM_WIDTH  read data; held until the next read response
//  rsp_err        out  1          parity mismatch on this response; qualified by rsp_valid
//  ram_blk_select out  1          RAM blk_select
//  ram_wr_en      out  1          RAM wr_en
//  ram_rd_en      out  1          RAM rd_en
//  ram_addr_en    out  1          RAM addr_en
//  ram_dout_en    out  1          RAM dout_en
//  ram_addr       out  ADDR_SIZE  RAM addr
//  ram_din        out  MEM_WIDTH  RAM din
//  ram_dout       in   MEM_WIDTH  RAM dout
//  ram_parity     in   1          RAM parity_out (even parity: ^dout)
// BEHAVIOUR
//  - All outputs are registered; on rst all outputs = 0, state = IDLE, latency counter = 0.
//  - req_ready = 1 only in IDLE. It rises on the first posedge after rst deasserts.
//  - States: IDLE, WR, RD, WAIT, RESP.
//  - IDLE: on accept, latch addr/wdata into ram_addr/ram_din.
//    req_wr=1 -> WR; req_wr=0 -> RD. req_ready drops in the same edge.
//  - WR, 1 cycle: ram_blk_select=1, ram_wr_en=1, all other strobes 0 -> IDLE.
//    Write-to-next-accept throughput is 2 cycles.
//  - RD, 1 cycle: ram_blk_select=1, ram_rd_en=1, ram_addr_en=1, ram_dout_en=1.
//    Load counter = RD_LATENCY-1 -> WAIT.
//  - WAIT: ram_blk_select=0, ram_rd_en=0, ram_dout_en held 1. Decrement the counter.
//    When counter==0, capture ram_dout -> rsp_rdata and compute rsp_err; go to RESP.
//    The capture edge ends cycle RD+RD_LATENCY.
//  - RESP, 1 cycle: rsp_valid=1, ram_dout_en=0 -> IDLE.
//    Accept-to-rsp_valid = RD_LATENCY+2 cycles.
//  - rsp_valid never asserts for writes. Only one request is outstanding at a time.
//  - req_valid while req_ready=0 is ignored. The requester holds the request until accepted.
//  - Addresses use the full ADDR_SIZE range; there is no wrap or range check (0 and 2^ADDR_SIZE-1 are legal).
//  - rst mid-operation (WR/RD/WAIT/RESP): strobes clear immediately.
//    The pending read is dropped with no rsp_valid; rsp_rdata clears to 0.
//  - Read following a write to the same address returns the new data.
//    The write completes in WR, before the next accept.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//    rsp_err = ram_parity ^ (^ram_dout), sampled at the capture edge.
//  PARITY_CHECK_EN undefined:
//    rsp_err is tied 0 and ram_parity is unused. Use for RAMs built with PARITY_ENABLE=0.
// TESTING
//  1. Hold rst=1 with random req_* -> all outputs 0.
//     Release -> req_ready=1 one posedge later.
//  2. Write addr 0x3F0, data 0xA5A5 -> exactly one cycle with ram_wr_en=1,
//     ram_addr=0x3F0, ram_din=0xA5A5; req_ready back 1 cycle later.
//  3. Read 0x3F0 (RD_LATENCY=2) -> ram_rd_en high 1 cycle;
//     rsp_valid 4 cycles after accept; rsp_rdata=0xA5A5, rsp_err=0.
//  4. With PARITY_CHECK_EN, force ram_parity inverted during the read of 0x0001
//     -> rsp_valid=1 with rsp_err=1. Without the macro -> rsp_err=0.
//  5. Assert rst in the WAIT cycle of a read -> no rsp_valid; all outputs 0.
//     The next read of 0x3FF completes normally.
//  6. Back-to-back: write 0x000=0x1234, then read 0x000 and 0x3FF with req_valid held high
//     -> ready gaps as specified; responses 0x1234, then the 0x3FF contents, in order.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single-outstanding request controller for one Pipelined_RAM.
// Takes a read or write request on a valid/ready port and drives the RAM strobes,
// address and write data. For a read it waits out the RAM read pipeline and returns
// the data with a parity-error flag as a one-cycle response pulse.
// Optional feature: define PARITY_CHECK_EN to compare ram_parity against the even
// parity of ram_dout at capture. Left undefined, rsp_err is tied 0.
module ram_access_ctrl #(
    parameter int MEM_WIDTH  = 16,
    parameter int ADDR_SIZE  = 10,
    parameter int RD_LATENCY = 2     // 1..7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [MEM_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [MEM_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 ram_blk_select,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity
);

    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] lat_cnt;

    logic accept;
    logic capture;
    logic capture_err;

    // Next values of the registered outputs, derived from the state being entered.
    logic nxt_req_ready;
    logic nxt_rsp_valid;
    logic nxt_blk_select;
    logic nxt_wr_en;
    logic nxt_rd_en;
    logic nxt_addr_en;
    logic nxt_dout_en;

    // req_ready is low during the first cycle out of reset, so it gates acceptance
    // rather than the IDLE state alone.
    assign accept  = req_valid && req_ready;
    assign capture = (state == ST_WAIT) && (lat_cnt == '0);

`ifdef PARITY_CHECK_EN
    assign capture_err = ram_parity ^ (^ram_dout);
`else
    logic unused_parity;
    assign capture_err   = 1'b0;
    assign unused_parity = ram_parity;
`endif

    // State register and registered outputs; everything returns to zero on reset.
    // NOTE: sequential state uses non-blocking (<=) so every register samples the
    // pre-edge values of its neighbours, exactly like the flops it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            ram_blk_select <= 1'b0;
            ram_wr_en      <= 1'b0;
            ram_rd_en      <= 1'b0;
            ram_addr_en    <= 1'b0;
            ram_dout_en    <= 1'b0;
        end else begin
            state          <= next_state;
            req_ready      <= nxt_req_ready;
            rsp_valid      <= nxt_rsp_valid;
            ram_blk_select <= nxt_blk_select;
            ram_wr_en      <= nxt_wr_en;
            ram_rd_en      <= nxt_rd_en;
            ram_addr_en    <= nxt_addr_en;
            ram_dout_en    <= nxt_dout_en;
        end
    end

    // Next-state decision.
    // NOTE: next_state gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = req_wr ? ST_WR : ST_RD;
            ST_WR:   next_state = ST_IDLE;
            ST_RD:   next_state = ST_WAIT;
            ST_WAIT: if (lat_cnt == '0) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from the state about to be entered, so the outputs can be registered.
    always_comb begin
        nxt_req_ready  = (next_state == ST_IDLE);
        nxt_rsp_valid  = (next_state == ST_RESP);
        nxt_blk_select = (next_state == ST_WR) || (next_state == ST_RD);
        nxt_wr_en      = (next_state == ST_WR);
        nxt_rd_en      = (next_state == ST_RD);
        nxt_addr_en    = (next_state == ST_RD);
        nxt_dout_en    = (next_state == ST_RD) || (next_state == ST_WAIT);
    end

    // Request latch, read-latency counter and response capture.
    // NOTE: the datapath registers are reset too, because reset must leave every
    // output at zero and drop a pending response; nothing here is a RAM array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_din   <= '0;
            lat_cnt   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && accept) begin
                ram_addr <= req_addr;
                ram_din  <= req_wdata;
            end

            // The RD cycle counts as the first pipeline cycle, hence the -1.
            if (state == ST_RD) begin
                lat_cnt <= CNT_W'(RD_LATENCY - 1);
            end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (capture) begin
                rsp_rdata <= ram_dout;
                rsp_err   <= capture_err;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Testbench for ram_access_ctrl: a behavioural Pipelined_RAM drives ram_dout, and a
// transaction-level model predicts every output from accept times and the latency
// rules. A compare process checks the DUT against the model on every falling edge,
// and directed tests add literal expectations.
module tb_ram_access_ctrl;

    localparam int MW     = 16;
    localparam int AW     = 10;
    localparam int RD_LAT = 2;
`ifdef PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [MW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [MW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_din;
    logic [MW-1:0] ram_dout;
    logic          ram_parity;
    logic          inv_par = 1'b0;

    int checks = 0;
    int errors = 0;

    ram_access_ctrl #(.MEM_WIDTH(MW), .ADDR_SIZE(AW), .RD_LATENCY(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_blk_select(ram_blk_select), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_parity(ram_parity)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural RAM: data valid RD_LAT cycles after the rd_en cycle
    logic [MW-1:0] ram_mem [2**AW];
    logic [MW-1:0] sh_d [RD_LAT];
    logic          sh_v [RD_LAT];

    always @(posedge clk) begin
        sh_d[0] <= ram_mem[ram_addr];
        sh_v[0] <= ram_blk_select && ram_rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            sh_d[i] <= sh_d[i-1];
            sh_v[i] <= sh_v[i-1];
        end
        if (ram_blk_select && ram_wr_en) ram_mem[ram_addr] <= ram_din;
    end

    // Outside the valid window the RAM shows junk, so a mistimed capture is visible.
    assign ram_dout   = sh_v[RD_LAT-1] ? sh_d[RD_LAT-1] : 16'hDEAD;
    assign ram_parity = (^ram_dout) ^ inv_par;

    // ---------------- transaction-level model, indexed by rising-edge count k
    logic [MW-1:0] shadow [2**AW];
    int            k = 0;
    int            ready_from = 1;
    int            wr_at = -100;
    int            rd_at = -100;
    logic [AW-1:0] m_addr = '0;
    logic [MW-1:0] m_din = '0;
    logic [MW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;
    logic [MW-1:0] rd_val = '0;
    logic          rd_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_from <= k + 1;
            wr_at      <= -100;
            rd_at      <= -100;
            m_addr     <= '0;
            m_din      <= '0;
            m_rdata    <= '0;
            m_err      <= 1'b0;
        end else begin
            k <= k + 1;
            if (k + 1 == rd_at + RD_LAT + 1) begin
                m_rdata <= rd_val;
                m_err   <= rd_err;
            end
            if (req_valid && k >= ready_from) begin
                m_addr <= req_addr;
                m_din  <= req_wdata;
                if (req_wr) begin
                    wr_at              <= k + 1;
                    ready_from         <= k + 2;
                    shadow[req_addr]   <= req_wdata;
                end else begin
                    rd_at      <= k + 1;
                    ready_from <= k + RD_LAT + 3;
                    rd_val     <= shadow[req_addr];
                    rd_err     <= PAR_EN && inv_par;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model
    always @(negedge clk) begin
        if (rst) begin
            check("rst_outputs_zero",
                  {req_ready, rsp_valid, rsp_err, ram_blk_select, ram_wr_en, ram_rd_en,
                   ram_addr_en, ram_dout_en}, 32'h0);
            check("rst_data_zero", {rsp_rdata, ram_din}, 32'h0);
            check("rst_addr_zero", ram_addr, 32'h0);
        end else begin
            check("req_ready",      req_ready,      k >= ready_from);
            check("ram_wr_en",      ram_wr_en,      k == wr_at);
            check("ram_rd_en",      ram_rd_en,      k == rd_at);
            check("ram_addr_en",    ram_addr_en,    k == rd_at);
            check("ram_blk_select", ram_blk_select, (k == wr_at) || (k == rd_at));
            check("ram_dout_en",    ram_dout_en,    (k >= rd_at) && (k <= rd_at + RD_LAT));
            check("rsp_valid",      rsp_valid,      k == rd_at + RD_LAT + 1);
            check("ram_addr",       ram_addr,       m_addr);
            check("ram_din",        ram_din,        m_din);
            check("rsp_rdata",      rsp_rdata,      m_rdata);
            if (k == rd_at + RD_LAT + 1) check("rsp_err", rsp_err, m_err);
        end
    end

    // Response log for the back-to-back test.
    logic [MW-1:0] rsp_q [$];
    always @(negedge clk) if (!rst && rsp_valid) rsp_q.push_back(rsp_rdata);

    // ---------------- directed stimulus
    // Presents a request and returns on the falling edge just after it is accepted;
    // req_valid is left high so callers can chain requests back to back.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [MW-1:0] data);
        bit ok = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", ok, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wr    = 1'b0;
    endtask

    // Called right after send(): waits for the response and checks latency and contents.
    task automatic wait_rsp(input string name, input logic [MW-1:0] exp_data, input logic exp_err);
        int n = 0;
        bit seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n = i;
                seen = 1;
                break;
            end
        end
        check({name, "_seen"}, seen, 1'b1);
        check({name, "_latency"}, n, RD_LAT + 1);
        check({name, "_data"}, rsp_rdata, exp_data);
        check({name, "_err"}, rsp_err, exp_err);
    endtask

    initial begin
        int no_rsp;
        for (int i = 0; i < 2**AW; i++) begin
            ram_mem[i] = 16'hC000 | 16'(i);
            shadow[i]  = 16'hC000 | 16'(i);
        end
        for (int i = 0; i < RD_LAT; i++) begin
            sh_v[i] = 1'b0;
            sh_d[i] = '0;
        end

        // 1: random requests under reset, then ready one edge after release
        repeat (5) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_wr    = 1'($urandom);
            req_addr  = AW'($urandom);
            req_wdata = MW'($urandom);
        end
        @(negedge clk);
        idle();
        #2 rst = 1'b0;
        #1 check("ready_before_first_edge", req_ready, 1'b0);
        @(negedge clk);
        check("ready_after_first_edge", req_ready, 1'b1);

        // 2: write 0x3F0 = 0xA5A5
        send(1'b1, 10'h3F0, 16'hA5A5);
        idle();
        check("wr_strobe", ram_wr_en, 1'b1);
        check("wr_addr", ram_addr, 10'h3F0);
        check("wr_din", ram_din, 16'hA5A5);
        check("wr_ready_low", req_ready, 1'b0);
        @(negedge clk);
        check("wr_strobe_single", ram_wr_en, 1'b0);
        check("wr_ready_back", req_ready, 1'b1);

        // 3: read back 0x3F0
        send(1'b0, 10'h3F0, 16'h0);
        idle();
        check("rd_strobe", ram_rd_en, 1'b1);
        wait_rsp("rd_3f0", 16'hA5A5, 1'b0);

        // 4: inverted parity on the read of 0x001
        @(negedge clk);
        inv_par = 1'b1;
        send(1'b0, 10'h001, 16'h0);
        idle();
        wait_rsp("rd_par", 16'hC001, PAR_EN);
        inv_par = 1'b0;

        // 5: reset during the WAIT cycle drops the read
        @(negedge clk);
        send(1'b0, 10'h3FF, 16'h0);
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_strobes", {ram_blk_select, ram_rd_en, ram_dout_en, ram_addr_en}, 4'h0);
        check("midrst_rsp", {rsp_valid, req_ready}, 2'b00);
        check("midrst_rdata", rsp_rdata, 16'h0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        no_rsp = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) no_rsp++;
        end
        check("midrst_no_rsp", no_rsp, 0);
        send(1'b0, 10'h3FF, 16'h0);
        idle();
        wait_rsp("rd_3ff", 16'hC3FF, 1'b0);

        // 6: back-to-back with req_valid held high
        @(negedge clk);
        rsp_q.delete();
        send(1'b1, 10'h000, 16'h1234);
        send(1'b0, 10'h000, 16'h0);
        send(1'b0, 10'h3FF, 16'h0);
        idle();
        for (int i = 0; i < 20 && rsp_q.size() < 2; i++) @(negedge clk);
        check("b2b_count", rsp_q.size(), 2);
        if (rsp_q.size() >= 2) begin
            check("b2b_first", rsp_q[0], 16'h1234);
            check("b2b_second", rsp_q[1], 16'hC3FF);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
